// File: rtl/zap_walk_wb_arb_pkg.sv
// Shared constants and types for the walker/cache-fill Wishbone arbiter.
package zap_localparams;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // One-hot bus owner encoding (bit0 = walker, bit1 = cache fill)
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // One Wishbone request as presented by a master or held on the bus
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

endpackage

// File: rtl/zap_walk_wb_arb_if.sv
// Memory-side Wishbone B3 classic bus driven by the arbiter.
interface zap_walk_wb_arb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic        ack;
    logic        err;
    logic [31:0] dat_r;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output ack, err, dat_r
    );
endinterface

// File: rtl/zap_wb_timeout_ctr.sv
// Bus watchdog: counts stalled strobe cycles and fires a single-cycle
// synthetic error when the stall reaches TIMEOUT_CYCLES. Zero disables it.
module zap_wb_timeout_ctr #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stb,
    input  logic ack,
    input  logic err,
    input  logic clr,
    output logic fire
);
    logic [31:0] cnt_q;
    logic        hit;

    // A real ack or err in the expiry cycle wins over the synthetic error.
    assign hit  = (TIMEOUT_CYCLES != 32'd0) && (cnt_q == (TIMEOUT_CYCLES - 32'd1));
    assign fire = hit & stb & ~ack & ~err;

    // Saturating stall counter; any response, idle strobe or owner exit restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else if (!stb || ack || err || clr || fire) begin
            cnt_q <= 32'd0;
        end else if (cnt_q != 32'hFFFF_FFFF) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end
endmodule

// File: rtl/zap_walk_wb_arb.sv
// Two-master Wishbone arbiter: TLB walker (m0) and cache line fill (m1)
// share one registered bus. The owner keeps the bus until it drops cyc,
// followed by one dead cycle before any new grant.
module zap_walk_wb_arb #(
    parameter bit          RR_EN          = 1'b1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        i_m0_wb_cyc_nxt,
    input  logic        i_m0_wb_stb_nxt,
    input  logic        i_m0_wb_wen_nxt,
    input  logic [31:0] i_m0_wb_adr_nxt,
    input  logic [3:0]  i_m0_wb_sel_nxt,
    input  logic [31:0] i_m0_wb_dat_nxt,
    output logic        o_m0_wb_ack,
    output logic        o_m0_wb_err,
    output logic [31:0] o_m0_wb_dat,

    input  logic        i_m1_wb_cyc_nxt,
    input  logic        i_m1_wb_stb_nxt,
    input  logic        i_m1_wb_wen_nxt,
    input  logic [31:0] i_m1_wb_adr_nxt,
    input  logic [3:0]  i_m1_wb_sel_nxt,
    input  logic [31:0] i_m1_wb_dat_nxt,
    output logic        o_m1_wb_ack,
    output logic        o_m1_wb_err,
    output logic [31:0] o_m1_wb_dat,

    zap_walk_wb_arb_if.master wb,

    output logic [1:0]  o_gnt,
    output logic        o_timeout
);
    import zap_localparams::*;

    wb_req_t    req0;
    wb_req_t    req1;
    wb_req_t    bus_q;
    logic [1:0] state_q;
    logic [1:0] gnt_q;
    logic       last_q;      // 0 = walker owned last, 1 = cache fill owned last
    logic       pick0;
    logic       own_drop;
    logic       syn_err;

    assign req0 = {i_m0_wb_cyc_nxt, i_m0_wb_stb_nxt, i_m0_wb_wen_nxt,
                   i_m0_wb_adr_nxt, i_m0_wb_sel_nxt, i_m0_wb_dat_nxt};
    assign req1 = {i_m1_wb_cyc_nxt, i_m1_wb_stb_nxt, i_m1_wb_wen_nxt,
                   i_m1_wb_adr_nxt, i_m1_wb_sel_nxt, i_m1_wb_dat_nxt};

    // Walker wins when alone, under fixed priority, or when fill went last
    assign pick0 = req0.cyc & (~req1.cyc | (RR_EN == 1'b0) | last_q);

    assign own_drop = ((state_q == ST_OWN0) & ~req0.cyc) |
                      ((state_q == ST_OWN1) & ~req1.cyc);

    // Ownership FSM; all bus outputs are flops so the bus never glitches
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
            bus_q   <= '0;
            gnt_q   <= GNT_NONE;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0.cyc || req1.cyc) begin
                        if (pick0) begin
                            state_q <= ST_OWN0;
                            bus_q   <= req0;
                            gnt_q   <= GNT_M0;
                            last_q  <= 1'b0;
                        end else begin
                            state_q <= ST_OWN1;
                            bus_q   <= req1;
                            gnt_q   <= GNT_M1;
                            last_q  <= 1'b1;
                        end
                    end
                end
                ST_OWN0: begin
                    if (req0.cyc) begin
                        bus_q <= req0;
                    end else begin
                        state_q <= ST_IDLE;
                        bus_q   <= '0;
                        gnt_q   <= GNT_NONE;
                    end
                end
                ST_OWN1: begin
                    if (req1.cyc) begin
                        bus_q <= req1;
                    end else begin
                        state_q <= ST_IDLE;
                        bus_q   <= '0;
                        gnt_q   <= GNT_NONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    bus_q   <= '0;
                    gnt_q   <= GNT_NONE;
                end
            endcase
        end
    end

    zap_wb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .stb   (bus_q.stb),
        .ack   (wb.ack),
        .err   (wb.err),
        .clr   (own_drop),
        .fire  (syn_err)
    );

    assign wb.cyc   = bus_q.cyc;
    assign wb.stb   = bus_q.stb;
    assign wb.we    = bus_q.we;
    assign wb.adr   = bus_q.adr;
    assign wb.sel   = bus_q.sel;
    assign wb.dat_w = bus_q.dat;

    assign o_gnt     = gnt_q;
    assign o_timeout = syn_err;

    // Responses reach only the current owner; with no owner they are dropped.
    assign o_m0_wb_ack = wb.ack & gnt_q[0];
    assign o_m0_wb_err = (wb.err | syn_err) & gnt_q[0];
    assign o_m0_wb_dat = gnt_q[0] ? wb.dat_r : 32'd0;
    assign o_m1_wb_ack = wb.ack & gnt_q[1];
    assign o_m1_wb_err = (wb.err | syn_err) & gnt_q[1];
    assign o_m1_wb_dat = gnt_q[1] ? wb.dat_r : 32'd0;
endmodule

// File: tb/tb_zap_walk_wb_arb.sv
// Bench for zap_walk_wb_arb: a round-robin instance with a 4-cycle watchdog
// and a fixed-priority instance without watchdog, driven by the same
// masters and slave, checked against an ownership-level reference model.
module tb_zap_walk_wb_arb;
    import zap_localparams::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    wb_req_t     r0, r1;
    logic        ack, err;
    logic [31:0] rdat;

    logic        a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_to;
    logic [31:0] a_m0_dat, a_m1_dat;
    logic [1:0]  a_gnt;
    logic        b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_to;
    logic [31:0] b_m0_dat, b_m1_dat;
    logic [1:0]  b_gnt;

    zap_walk_wb_arb_if bus_a ();
    zap_walk_wb_arb_if bus_b ();
    assign bus_a.ack = ack;  assign bus_a.err = err;  assign bus_a.dat_r = rdat;
    assign bus_b.ack = ack;  assign bus_b.err = err;  assign bus_b.dat_r = rdat;

    always #5 clk = ~clk;

    zap_walk_wb_arb #(.RR_EN(1'b1), .TIMEOUT_CYCLES(32'd4)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_wb_cyc_nxt(r0.cyc), .i_m0_wb_stb_nxt(r0.stb), .i_m0_wb_wen_nxt(r0.we),
        .i_m0_wb_adr_nxt(r0.adr), .i_m0_wb_sel_nxt(r0.sel), .i_m0_wb_dat_nxt(r0.dat),
        .o_m0_wb_ack(a_m0_ack), .o_m0_wb_err(a_m0_err), .o_m0_wb_dat(a_m0_dat),
        .i_m1_wb_cyc_nxt(r1.cyc), .i_m1_wb_stb_nxt(r1.stb), .i_m1_wb_wen_nxt(r1.we),
        .i_m1_wb_adr_nxt(r1.adr), .i_m1_wb_sel_nxt(r1.sel), .i_m1_wb_dat_nxt(r1.dat),
        .o_m1_wb_ack(a_m1_ack), .o_m1_wb_err(a_m1_err), .o_m1_wb_dat(a_m1_dat),
        .wb(bus_a), .o_gnt(a_gnt), .o_timeout(a_to)
    );

    zap_walk_wb_arb #(.RR_EN(1'b0), .TIMEOUT_CYCLES(32'd0)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_m0_wb_cyc_nxt(r0.cyc), .i_m0_wb_stb_nxt(r0.stb), .i_m0_wb_wen_nxt(r0.we),
        .i_m0_wb_adr_nxt(r0.adr), .i_m0_wb_sel_nxt(r0.sel), .i_m0_wb_dat_nxt(r0.dat),
        .o_m0_wb_ack(b_m0_ack), .o_m0_wb_err(b_m0_err), .o_m0_wb_dat(b_m0_dat),
        .i_m1_wb_cyc_nxt(r1.cyc), .i_m1_wb_stb_nxt(r1.stb), .i_m1_wb_wen_nxt(r1.we),
        .i_m1_wb_adr_nxt(r1.adr), .i_m1_wb_sel_nxt(r1.sel), .i_m1_wb_dat_nxt(r1.dat),
        .o_m1_wb_ack(b_m1_ack), .o_m1_wb_err(b_m1_err), .o_m1_wb_dat(b_m1_dat),
        .wb(bus_b), .o_gnt(b_gnt), .o_timeout(b_to)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner per instance (0 none, 1 walker, 2 fill),
    // who owned last, the request the bus should be showing, stall count.
    int          own [2];
    int          last [2];
    wb_req_t     mbus [2];
    int unsigned cnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_req_t req_of(int o);
        if (o == 1) return r0;
        if (o == 2) return r1;
        return '0;
    endfunction

    function automatic logic [1:0] gnt_of(int o);
        if (o == 1) return 2'b01;
        if (o == 2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic fire_now();
        return mbus[0].stb && !ack && !err && (cnt == T - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; last[k] = 2; mbus[k] = '0;
        end
        cnt = 0;
    endtask

    task automatic model_edge();
        logic f, lv;
        int   p;
        f  = fire_now();
        lv = (own[0] != 0) && !req_of(own[0]).cyc;
        if (!mbus[0].stb || ack || err || lv || f) cnt = 0;
        else if (cnt != 32'hFFFF_FFFF) cnt++;
        for (int k = 0; k < 2; k++) begin
            if (own[k] == 0) begin
                p = 0;
                if (r0.cyc && r1.cyc) p = (k == 0) ? ((last[k] == 2) ? 1 : 2) : 1;
                else if (r0.cyc) p = 1;
                else if (r1.cyc) p = 2;
                if (p != 0) begin
                    own[k] = p; last[k] = p; mbus[k] = req_of(p);
                end
            end else if (!req_of(own[k]).cyc) begin
                own[k] = 0; mbus[k] = '0;
            end else begin
                mbus[k] = req_of(own[k]);
            end
        end
    endtask

    task automatic check_comb();
        logic f;
        f = fire_now();
        chk("a_m0_ack", a_m0_ack, ack && own[0] == 1);
        chk("a_m0_err", a_m0_err, (err || f) && own[0] == 1);
        chk("a_m0_dat", a_m0_dat, (own[0] == 1) ? rdat : 32'd0);
        chk("a_m1_ack", a_m1_ack, ack && own[0] == 2);
        chk("a_m1_err", a_m1_err, (err || f) && own[0] == 2);
        chk("a_m1_dat", a_m1_dat, (own[0] == 2) ? rdat : 32'd0);
        chk("a_timeout", a_to, f);
        chk("b_m0_ack", b_m0_ack, ack && own[1] == 1);
        chk("b_m0_err", b_m0_err, err && own[1] == 1);
        chk("b_m0_dat", b_m0_dat, (own[1] == 1) ? rdat : 32'd0);
        chk("b_m1_ack", b_m1_ack, ack && own[1] == 2);
        chk("b_m1_err", b_m1_err, err && own[1] == 2);
        chk("b_m1_dat", b_m1_dat, (own[1] == 2) ? rdat : 32'd0);
        chk("b_timeout", b_to, 1'b0);
    endtask

    task automatic check_regs();
        chk("a_gnt", a_gnt, gnt_of(own[0]));
        chk("a_bus", {bus_a.cyc, bus_a.stb, bus_a.we, bus_a.adr, bus_a.sel, bus_a.dat_w}, mbus[0]);
        chk("b_gnt", b_gnt, gnt_of(own[1]));
        chk("b_bus", {bus_b.cyc, bus_b.stb, bus_b.we, bus_b.adr, bus_b.sel, bus_b.dat_w}, mbus[1]);
    endtask

    // Called at posedge+1 with inputs set: settle to the falling edge, check responses.
    task automatic cyc_a();
        #4;
        check_comb();
    endtask

    // Commit the edge in the model, then check registered outputs at posedge+1.
    task automatic cyc_b();
        model_edge();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic cycle();
        cyc_a();
        cyc_b();
    endtask

    function automatic wb_req_t mk(logic we, logic [31:0] adr, logic [31:0] dat);
        wb_req_t r;
        r.cyc = 1'b1; r.stb = 1'b1; r.we = we; r.adr = adr; r.sel = 4'hF; r.dat = dat;
        return r;
    endfunction

    initial begin
        int          held;
        int          cur;
        logic [1:0]  prev_nz;
        logic [1:0]  prev_g;

        // Reset with both masters requesting
        rst_n = 1'b0;
        ack = 1'b1; err = 1'b0; rdat = 32'hDEAD_BEEF;
        r0 = mk(1'b0, 32'h0000_4000, 32'd0);
        r1 = mk(1'b0, 32'h8000_0010, 32'd0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_regs();
        #4;
        check_comb();
        @(posedge clk); #1;
        ack = 1'b0;
        rst_n = 1'b1;
        cycle();
        chk("rst_first_gnt", a_gnt, 2'b01);
        chk("rst_first_adr", bus_a.adr, 32'h0000_4000);
        chk("rst_first_gnt_fp", b_gnt, 2'b01);

        // Walker releases; dead cycle, then the fill master gets the bus
        cycle();
        r0 = '0;
        cycle();
        chk("dead_cycle", a_gnt, 2'b00);
        cycle();
        chk("fill_gnt", a_gnt, 2'b10);

        // Fill master 4-beat read, acked every cycle
        for (int beat = 0; beat < 4; beat++) begin
            ack = 1'b1; rdat = 32'hA000_0000 + beat;
            if (beat < 3) r1.adr = 32'h8000_0010 + 4 * (beat + 1);
            else r1 = '0;
            cyc_a();
            chk("burst_adr", bus_a.adr, 32'h8000_0010 + 4 * beat);
            chk("burst_m1_ack", a_m1_ack, 1'b1);
            chk("burst_m0_ack", a_m0_ack, 1'b0);
            cyc_b();
        end
        ack = 1'b0;
        cycle();

        // Continuous contention: owner drops after two owned cycles, then re-requests
        held = 0; cur = 0; prev_nz = 2'b10; prev_g = a_gnt;
        for (int i = 0; i < 24; i++) begin
            r0 = (own[0] == 1 && held >= 2) ? wb_req_t'('0) : mk(1'b0, 32'h0000_4000, 32'd0);
            r1 = (own[0] == 2 && held >= 2) ? wb_req_t'('0) : mk(1'b0, 32'h8000_0020, 32'd0);
            cycle();
            if (own[0] != 0 && own[0] == cur) held++;
            else held = (own[0] != 0) ? 1 : 0;
            cur = own[0];
            if (a_gnt != 2'b00 && prev_g == 2'b00) begin
                chk("rr_alternate", a_gnt, (prev_nz == 2'b01) ? 2'b10 : 2'b01);
                prev_nz = a_gnt;
            end
            prev_g = a_gnt;
        end
        r0 = '0; r1 = '0;
        cycle(); cycle(); cycle();

        // Walker request arrives while the fill master owns the bus
        r1 = mk(1'b0, 32'h8000_0040, 32'd0);
        cycle(); cycle();
        r0 = mk(1'b0, 32'h0000_4000, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("walker_waits", a_gnt, 2'b10);
            chk("no_walker_adr", (a_gnt == 2'b10) && (bus_a.adr == 32'h0000_4000), 1'b0);
        end
        r1 = '0;
        cycle();
        chk("handover_dead", a_gnt, 2'b00);
        cycle();
        chk("handover_walker", a_gnt, 2'b01);
        r0 = '0;
        cycle(); cycle();

        // Watchdog: no response, error on the fourth strobe cycle
        r0 = mk(1'b0, 32'h0000_5000, 32'd0);
        cycle();
        for (int s = 1; s <= 4; s++) begin
            cyc_a();
            chk("wd_timeout", a_to, s == 4);
            chk("wd_err", a_m0_err, s == 4);
            if (s == 4) r0 = '0;
            cyc_b();
        end
        cycle(); cycle();

        // Watchdog: ack lands on the expiry cycle, no error
        r0 = mk(1'b0, 32'h0000_6000, 32'd0);
        cycle();
        for (int s = 1; s <= 4; s++) begin
            ack = (s == 4);
            cyc_a();
            chk("wd_ack_to", a_to, 1'b0);
            chk("wd_ack_err", a_m0_err, 1'b0);
            if (s == 4) begin
                chk("wd_ack_fwd", a_m0_ack, 1'b1);
                r0 = '0;
            end
            cyc_b();
        end
        ack = 1'b0;
        cycle(); cycle();

        // Bus error during a fill-master write
        r1 = mk(1'b1, 32'h8000_0100, $urandom);
        cycle();
        err = 1'b1;
        cyc_a();
        chk("berr_m1", a_m1_err, 1'b1);
        chk("berr_m0", a_m0_err, 1'b0);
        r1 = '0;
        cyc_b();
        err = 1'b0;
        chk("berr_cyc_drop", bus_a.cyc, 1'b0);
        chk("berr_idle", a_gnt, 2'b00);
        cycle();

        // Asynchronous reset in the middle of a walker burst
        r0 = mk(1'b0, 32'h0000_7000, 32'd0);
        cycle(); cycle();
        ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_gnt", a_gnt, 2'b00);
        chk("arst_cyc", bus_a.cyc, 1'b0);
        chk("arst_ack", a_m0_ack, 1'b0);
        @(posedge clk); #1;
        check_regs();
        ack = 1'b0;
        rst_n = 1'b1;
        cycle();
        r0 = '0;
        cycle();

        // Randomized traffic from both masters and the slave
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) r0.cyc = ~r0.cyc;
            if ($urandom_range(0, 5) == 0) r1.cyc = ~r1.cyc;
            if (r0.cyc) begin
                r0.stb = ($urandom_range(0, 3) != 0); r0.we = $urandom_range(0, 1);
                r0.adr = $urandom; r0.sel = 4'($urandom); r0.dat = $urandom;
            end else r0 = '0;
            if (r1.cyc) begin
                r1.stb = ($urandom_range(0, 3) != 0); r1.we = $urandom_range(0, 1);
                r1.adr = $urandom; r1.sel = 4'($urandom); r1.dat = $urandom;
            end else r1 = '0;
            ack  = ($urandom_range(0, 4) == 0);
            err  = ($urandom_range(0, 19) == 0);
            rdat = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
